// File: rtl/sramb_pkg.sv
// Shared types and helpers for the true dual-port byte-lane RAM.
//   sramb_state_e   : clear sequencer states
//   RDW_*           : same-port read-during-write mode encodings
//   lane_merge()    : replace the masked lanes of a word with new data
package sramb_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } sramb_state_e;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    // Upper bounds for the generic merge helper; callers zero-extend into
    // these widths and cast the result back to their own word width.
    localparam int MAX_DW    = 256;
    localparam int MAX_LANES = 32;

    function automatic logic [MAX_DW-1:0] lane_merge(
        input logic [MAX_DW-1:0]    old_w,
        input logic [MAX_DW-1:0]    new_w,
        input logic [MAX_LANES-1:0] mask,
        input int                   lanes,
        input int                   width
    );
        logic [MAX_DW-1:0] bit_mask;
        logic [MAX_DW-1:0] lane_ones;
        int                lw;
        lw        = width / lanes;
        lane_ones = {MAX_DW{1'b1}} >> (MAX_DW - lw);
        bit_mask  = '0;
        for (int l = 0; l < MAX_LANES; l++) begin
            if (l < lanes && mask[l]) begin
                bit_mask = bit_mask | (lane_ones << (l * lw));
            end
        end
        return (old_w & ~bit_mask) | (new_w & bit_mask);
    endfunction

endpackage

// File: rtl/sramb_clear_seq.sv
// Post-reset clear sequencer: walks every address once writing zero, then
// hands the memory to the user ports by raising ready.
//   CLK, RST   : clock, async active-high reset
//   ready      : user accesses accepted (registered state, glitch-free)
//   clr_we     : clear write strobe for this cycle
//   clr_addr   : address being cleared
//
//   state | meaning
//   ------+---------------------------------------------------------
//   CLEAR | zeroing word cnt each cycle; user ports locked out
//   RUN   | clear done, ready=1; terminal until reset
module sramb_clear_seq
    import sramb_pkg::*;
#(
    parameter int ADDR_WIDTH    = 6,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic                  ready,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    // One extra counter bit keeps the terminal compare exact at full depth.
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(2**ADDR_WIDTH - 1);

    sramb_state_e          state, state_nxt;
    logic [ADDR_WIDTH:0]   cnt, cnt_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        ready     = 1'b0;
        case (state)
            CLEAR: begin
                if (INIT_ON_RESET == 0) begin
                    state_nxt = RUN;
                end else begin
                    clr_we  = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == LAST) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                ready = 1'b1;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    assign clr_addr = cnt[ADDR_WIDTH-1:0];

endmodule

// File: rtl/sramb_tdp_be.sv
// True dual-port block RAM with per-lane write enables on both ports,
// selectable same-port read-during-write, optional output register and a
// built-in zero-clear after reset.
//   CLK, RST                 : clock, async active-high reset
//   ENx, WEx, BEx, ADDRx, DIx: port x access enable, write, lane enables,
//                              address, write data (x = A, B)
//   DOx, VALIDx              : port x read data and its one-cycle strobe
//   READY                    : clear finished, user accesses accepted
module sramb_tdp_be
    import sramb_pkg::*;
#(
    parameter int ADDR_WIDTH    = 6,
    parameter int DATA_WIDTH    = 16,
    parameter int LANES         = 2,
    parameter int RDW_MODE      = 0,
    parameter int OUT_REG       = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENA,
    input  logic                  WEA,
    input  logic [LANES-1:0]      BEA,
    input  logic [ADDR_WIDTH-1:0] ADDRA,
    input  logic [DATA_WIDTH-1:0] DIA,
    output logic [DATA_WIDTH-1:0] DOA,
    output logic                  VALIDA,
    input  logic                  ENB,
    input  logic                  WEB,
    input  logic [LANES-1:0]      BEB,
    input  logic [ADDR_WIDTH-1:0] ADDRB,
    input  logic [DATA_WIDTH-1:0] DIB,
    output logic [DATA_WIDTH-1:0] DOB,
    output logic                  VALIDB,
    output logic                  READY
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int LW    = DATA_WIDTH / LANES;

    logic                  ready;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    sramb_clear_seq #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .INIT_ON_RESET (INIT_ON_RESET)
    ) u_clear_seq (
        .CLK      (CLK),
        .RST      (RST),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign READY = ready;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  acc_a, acc_b;
    logic [LANES-1:0]      wmask_a, wmask_b;
    logic [DATA_WIDTH-1:0] rd_a, rd_b;

    assign acc_a   = ready & ENA;
    assign acc_b   = ready & ENB;
    assign wmask_a = (acc_a && WEA) ? BEA : '0;
    assign wmask_b = (acc_b && WEB) ? BEB : '0;

    // Port B lanes are written first so that port A wins a same-lane collision.
    always_ff @(posedge CLK) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (ready) begin
            for (int l = 0; l < LANES; l++) begin
                if (wmask_b[l]) begin
                    mem[ADDRB][l*LW +: LW] <= DIB[l*LW +: LW];
                end
            end
            for (int l = 0; l < LANES; l++) begin
                if (wmask_a[l]) begin
                    mem[ADDRA][l*LW +: LW] <= DIA[l*LW +: LW];
                end
            end
        end
    end

    // Only the port's own write is merged; the other port's write in the
    // same cycle is never visible, so cross-port reads see the old word.
    always_comb begin
        rd_a = mem[ADDRA];
        rd_b = mem[ADDRB];
        if (RDW_MODE == RDW_WRITE_FIRST) begin
            rd_a = DATA_WIDTH'(lane_merge(MAX_DW'(mem[ADDRA]), MAX_DW'(DIA),
                                          MAX_LANES'(wmask_a), LANES, DATA_WIDTH));
            rd_b = DATA_WIDTH'(lane_merge(MAX_DW'(mem[ADDRB]), MAX_DW'(DIB),
                                          MAX_LANES'(wmask_b), LANES, DATA_WIDTH));
        end
    end

    logic [DATA_WIDTH-1:0] do1_a, do1_b;
    logic                  v1_a, v1_b;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            do1_a <= '0;
            do1_b <= '0;
            v1_a  <= 1'b0;
            v1_b  <= 1'b0;
        end else begin
            v1_a <= acc_a;
            v1_b <= acc_b;
            if (acc_a) do1_a <= rd_a;
            if (acc_b) do1_b <= rd_b;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] do2_a, do2_b;
            logic                  v2_a, v2_b;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    do2_a <= '0;
                    do2_b <= '0;
                    v2_a  <= 1'b0;
                    v2_b  <= 1'b0;
                end else begin
                    v2_a <= v1_a;
                    v2_b <= v1_b;
                    if (v1_a) do2_a <= do1_a;
                    if (v1_b) do2_b <= do1_b;
                end
            end

            assign DOA    = do2_a;
            assign DOB    = do2_b;
            assign VALIDA = v2_a;
            assign VALIDB = v2_b;
        end else begin : g_no_out_reg
            assign DOA    = do1_a;
            assign DOB    = do1_b;
            assign VALIDA = v1_a;
            assign VALIDB = v1_b;
        end
    endgenerate

endmodule
